// File: rtl/frontend_response_tagger_if.sv
// Handshake bundle for the frontend response tagger: request in, backend
// command out, backend completion in, tagged response out.
interface frontend_response_tagger_if #(
    parameter int DATA_WIDTH = 64
);
    // Request from the interconnect arbiter
    logic                  req_valid;
    logic                  req_ready;
    logic [19:0]           req;

    // Untagged command to the backend scheduler
    logic                  be_cmd_valid;
    logic                  be_cmd_ready;
    logic                  be_cmd_op;
    logic [1:0]            be_cmd_data_type;
    logic [9:0]            be_cmd_addr;

    // In-order completion from the backend
    logic                  be_done;
    logic [DATA_WIDTH-1:0] be_rdata;

    // Tagged response back to the originating core
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_op;
    logic [4:0]            resp_req_id;
    logic [1:0]            resp_core_num;
    logic [DATA_WIDTH-1:0] resp_data;

    // Sticky error flag
    logic                  err_underflow;

    // Environment side: drives requests, backend and response consumer
    modport master (
        output req_valid, req,
        input  req_ready,
        input  be_cmd_valid, be_cmd_op, be_cmd_data_type, be_cmd_addr,
        output be_cmd_ready,
        output be_done, be_rdata,
        input  resp_valid, resp_op, resp_req_id, resp_core_num, resp_data,
        output resp_ready,
        input  err_underflow
    );

    // Tagger side
    modport slave (
        input  req_valid, req,
        output req_ready,
        output be_cmd_valid, be_cmd_op, be_cmd_data_type, be_cmd_addr,
        input  be_cmd_ready,
        input  be_done, be_rdata,
        output resp_valid, resp_op, resp_req_id, resp_core_num, resp_data,
        input  resp_ready,
        output err_underflow
    );
endinterface

// File: rtl/frontend_response_tagger.sv
// Frontend response tagger: forwards untagged commands to the backend,
// keeps tags in arrival order and re-attaches them to in-order completions.
module frontend_response_tagger #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 64
) (
    input logic                      clk,
    input logic                      rst,
    frontend_response_tagger_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       op;
        logic [1:0] data_type;
        logic [9:0] addr;
        logic [4:0] req_id;
        logic [1:0] core_num;
    } req_t;

    typedef struct packed {
        logic       op;
        logic [4:0] req_id;
        logic [1:0] core_num;
    } tag_t;

    typedef struct packed {
        tag_t                  tag;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    // Outstanding counter covers entries in both FIFOs plus in-flight
    // commands, so the response FIFO can never overflow on be_done.
    logic [CW-1:0] out_q, out_d;
    logic          err_q, err_d;

    // Tag FIFO state
    tag_t          tag_mem_q [DEPTH];
    logic [AW-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d;

    // Response FIFO state
    resp_t         resp_mem_q [DEPTH];
    logic [AW-1:0] resp_wr_q, resp_wr_d;
    logic [AW-1:0] resp_rd_q, resp_rd_d;
    logic [CW-1:0] resp_cnt_q, resp_cnt_d;

    req_t  req_s;
    tag_t  tag_in;
    tag_t  tag_head;
    resp_t resp_in;
    resp_t resp_head;
    logic  space;
    logic  accept;
    logic  tag_empty;
    logic  tag_pop;
    logic  resp_valid;
    logic  resp_pop;

    assign req_s     = req_t'(bus.req);
    assign space     = (out_q < CW'(DEPTH));
    assign accept    = bus.req_valid & bus.be_cmd_ready & space;
    assign tag_empty = (tag_cnt_q == '0);
    assign tag_pop   = bus.be_done & ~tag_empty;
    assign resp_valid = (resp_cnt_q != '0);
    assign resp_pop  = resp_valid & bus.resp_ready;

    assign tag_in.op       = req_s.op;
    assign tag_in.req_id   = req_s.req_id;
    assign tag_in.core_num = req_s.core_num;

    assign tag_head     = tag_mem_q[tag_rd_q];
    assign resp_in.tag  = tag_head;
    assign resp_in.data = tag_head.op ? bus.be_rdata : '0;
    assign resp_head    = resp_mem_q[resp_rd_q];

    // Combinational pass-through to the backend
    assign bus.be_cmd_valid     = bus.req_valid & space;
    assign bus.req_ready        = bus.be_cmd_ready & space;
    assign bus.be_cmd_op        = req_s.op;
    assign bus.be_cmd_data_type = req_s.data_type;
    assign bus.be_cmd_addr      = req_s.addr;

    // Response head, forced to zero while the FIFO is empty
    assign bus.resp_valid    = resp_valid;
    assign bus.resp_op       = resp_valid ? resp_head.tag.op       : 1'b0;
    assign bus.resp_req_id   = resp_valid ? resp_head.tag.req_id   : 5'd0;
    assign bus.resp_core_num = resp_valid ? resp_head.tag.core_num : 2'd0;
    assign bus.resp_data     = resp_valid ? resp_head.data         : '0;
    assign bus.err_underflow = err_q;

    // Next-state for pointers, occupancy counts and the error flag
    always_comb begin
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        tag_cnt_d  = tag_cnt_q;
        resp_wr_d  = resp_wr_q;
        resp_rd_d  = resp_rd_q;
        resp_cnt_d = resp_cnt_q;
        out_d      = out_q;
        err_d      = err_q;

        if (accept) begin
            tag_wr_d = tag_wr_q + AW'(1);
        end
        if (tag_pop) begin
            tag_rd_d  = tag_rd_q + AW'(1);
            resp_wr_d = resp_wr_q + AW'(1);
        end
        if (resp_pop) begin
            resp_rd_d = resp_rd_q + AW'(1);
        end

        tag_cnt_d  = tag_cnt_q + CW'(accept) - CW'(tag_pop);
        resp_cnt_d = resp_cnt_q + CW'(tag_pop) - CW'(resp_pop);
        out_d      = out_q + CW'(accept) - CW'(resp_pop);

        if (bus.be_done && tag_empty) begin
            err_d = 1'b1;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            resp_wr_q  <= '0;
            resp_rd_q  <= '0;
            resp_cnt_q <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_cnt_q  <= tag_cnt_d;
            resp_wr_q  <= resp_wr_d;
            resp_rd_q  <= resp_rd_d;
            resp_cnt_q <= resp_cnt_d;
            out_q      <= out_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents are don't-care until their count covers them
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem_q[tag_wr_q] <= tag_in;
        end
        if (tag_pop) begin
            resp_mem_q[resp_wr_q] <= resp_in;
        end
    end
endmodule

// File: tb/tb_frontend_response_tagger.sv
// Testbench for frontend_response_tagger: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_frontend_response_tagger;
    localparam int DEPTH = 8;
    localparam int DW    = 64;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    typedef struct {
        logic       op;
        logic [4:0] id;
        logic [1:0] core;
    } mtag_t;

    typedef struct {
        logic          op;
        logic [4:0]    id;
        logic [1:0]    core;
        logic [DW-1:0] data;
    } mresp_t;

    mtag_t  tagq [$];
    mresp_t respq [$];
    int     m_out;
    bit     m_err;

    frontend_response_tagger_if #(.DATA_WIDTH(DW)) bus ();

    frontend_response_tagger #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mkreq(input logic op, input logic [1:0] dt,
                                          input logic [9:0] a,
                                          input logic [4:0] id,
                                          input logic [1:0] c);
        return {op, dt, a, id, c};
    endfunction

    // Compare all outputs against the model's view of the current cycle
    task automatic check_outputs();
        bit            space;
        logic [19:0]   r;
        space = (m_out < DEPTH);
        r = bus.req;
        chk("req_ready", bus.req_ready, bus.be_cmd_ready & space);
        chk("be_cmd_valid", bus.be_cmd_valid, bus.req_valid & space);
        chk("be_cmd_op", bus.be_cmd_op, r[19]);
        chk("be_cmd_dt", bus.be_cmd_data_type, r[18:17]);
        chk("be_cmd_addr", bus.be_cmd_addr, r[16:7]);
        chk("err_underflow", bus.err_underflow, m_err);
        chk("resp_valid", bus.resp_valid, respq.size() > 0);
        if (respq.size() > 0) begin
            chk("resp_op", bus.resp_op, respq[0].op);
            chk("resp_id", bus.resp_req_id, respq[0].id);
            chk("resp_core", bus.resp_core_num, respq[0].core);
            chk("resp_data", bus.resp_data, respq[0].data);
        end else begin
            chk("resp_op_idle", bus.resp_op, 1'b0);
            chk("resp_id_idle", bus.resp_req_id, 5'd0);
            chk("resp_core_idle", bus.resp_core_num, 2'd0);
            chk("resp_data_idle", bus.resp_data, '0);
        end
    endtask

    // Advance the model by one clock using the inputs seen at the edge
    task automatic update_model();
        bit     acc;
        bit     pop;
        mtag_t  t;
        mresp_t rs;
        if (rst) begin
            tagq.delete();
            respq.delete();
            m_out = 0;
            m_err = 1'b0;
            return;
        end
        acc = bus.req_valid && bus.be_cmd_ready && (m_out < DEPTH);
        pop = (respq.size() > 0) && bus.resp_ready;
        if (pop) begin
            void'(respq.pop_front());
            m_out--;
        end
        if (bus.be_done) begin
            if (tagq.size() > 0) begin
                t = tagq.pop_front();
                rs.op   = t.op;
                rs.id   = t.id;
                rs.core = t.core;
                rs.data = t.op ? bus.be_rdata : '0;
                respq.push_back(rs);
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc) begin
            t.op   = bus.req[19];
            t.id   = bus.req[6:2];
            t.core = bus.req[1:0];
            tagq.push_back(t);
            m_out++;
        end
    endtask

    task automatic cycle();
        #1;
        if (chk_en) check_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req          = '0;
        bus.be_cmd_ready = 1'b1;
        bus.be_done      = 1'b0;
        bus.be_rdata     = '0;
        bus.resp_ready   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        m_out    = 0;
        m_err    = 1'b0;
        rst      = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Reset state
        #1;
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_err", bus.err_underflow, 1'b0);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        cycle();

        // Single read
        bus.req_valid = 1'b1;
        bus.req = mkreq(1'b1, 2'd0, 10'h155, 5'd7, 2'd2);
        cycle();
        idle_inputs();
        bus.be_done  = 1'b1;
        bus.be_rdata = 64'hDEAD_BEEF;
        cycle();
        idle_inputs();
        #1;
        chk("rd_valid", bus.resp_valid, 1'b1);
        chk("rd_op", bus.resp_op, 1'b1);
        chk("rd_id", bus.resp_req_id, 5'd7);
        chk("rd_core", bus.resp_core_num, 2'd2);
        chk("rd_data", bus.resp_data, 64'hDEAD_BEEF);
        cycle();
        bus.resp_ready = 1'b1;
        cycle();

        // Write ack returns zero data
        idle_inputs();
        bus.req_valid = 1'b1;
        bus.req = mkreq(1'b0, 2'd1, 10'h3FF, 5'd31, 2'd3);
        cycle();
        idle_inputs();
        bus.be_done  = 1'b1;
        bus.be_rdata = '1;
        cycle();
        idle_inputs();
        #1;
        chk("wr_op", bus.resp_op, 1'b0);
        chk("wr_id", bus.resp_req_id, 5'd31);
        chk("wr_core", bus.resp_core_num, 2'd3);
        chk("wr_data", bus.resp_data, '0);
        bus.resp_ready = 1'b1;
        cycle();
        idle_inputs();

        // Fill to DEPTH with responses held back
        for (int i = 0; i < DEPTH; i++) begin
            bus.req_valid = 1'b1;
            bus.req = mkreq(1'b1, 2'(i), 10'(i * 3), 5'(i), 2'(i % 4));
            cycle();
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.be_done  = 1'b1;
            bus.be_rdata = 64'(100 + i);
            cycle();
        end
        bus.be_done   = 1'b0;
        bus.req_valid = 1'b1;
        bus.req = mkreq(1'b0, 2'd2, 10'h0AA, 5'd8, 2'd0);
        #1;
        chk("full_req_ready", bus.req_ready, 1'b0);
        chk("full_cmd_valid", bus.be_cmd_valid, 1'b0);
        cycle();
        bus.resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("order_id", bus.resp_req_id, 5'(i));
            if (i == 1) chk("ready_after_pop", bus.req_ready, 1'b1);
            cycle();
            bus.req_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) cycle();
        idle_inputs();

        // Full outstanding with completion and pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            bus.req_valid = 1'b1;
            bus.req = mkreq(1'(i % 2), 2'd3, 10'(i), 5'(16 + i), 2'(3 - i % 4));
            bus.be_done  = (i >= 1 && i <= 4);
            bus.be_rdata = 64'(200 + i);
            cycle();
        end
        bus.req_valid  = 1'b0;
        bus.be_done    = 1'b1;
        bus.be_rdata   = 64'h55;
        bus.resp_ready = 1'b1;
        cycle();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            bus.be_done  = (tagq.size() > 0);
            bus.be_rdata = 64'(300 + i);
            bus.resp_ready = (i % 3 != 1);
            cycle();
        end
        idle_inputs();

        // Underflow is sticky until reset
        do_reset();
        bus.be_done = 1'b1;
        cycle();
        bus.be_done = 1'b0;
        #1;
        chk("uf_err", bus.err_underflow, 1'b1);
        chk("uf_no_resp", bus.resp_valid, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("uf_sticky", bus.err_underflow, 1'b1);
        do_reset();
        #1;
        chk("uf_cleared", bus.err_underflow, 1'b0);

        // Reset mid-stream discards outstanding work
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1;
            bus.req = mkreq(1'b1, 2'd0, 10'(i), 5'(i + 20), 2'd1);
            bus.be_done = (i == 2);
            bus.be_rdata = 64'hABC;
            cycle();
        end
        idle_inputs();
        do_reset();
        #1;
        chk("mid_rst_valid", bus.resp_valid, 1'b0);
        bus.req_valid = 1'b1;
        bus.req = mkreq(1'b1, 2'd1, 10'h123, 5'd9, 2'd3);
        cycle();
        idle_inputs();
        bus.be_done  = 1'b1;
        bus.be_rdata = 64'h1234_5678_9ABC_DEF0;
        cycle();
        idle_inputs();
        #1;
        chk("post_rst_id", bus.resp_req_id, 5'd9);
        chk("post_rst_data", bus.resp_data, 64'h1234_5678_9ABC_DEF0);
        bus.resp_ready = 1'b1;
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.req_valid    = $urandom_range(0, 1) == 1;
            bus.req          = 20'($urandom);
            bus.be_cmd_ready = $urandom_range(0, 3) != 0;
            bus.be_done      = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.be_rdata     = {$urandom, $urandom};
            bus.resp_ready   = $urandom_range(0, 2) != 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
